// File: rtl/serial_adder_controller.sv
// Bit-serial adder: one full-adder cell reused for WIDTH clocks, LSB first,
// behind a start/busy/done handshake.
module serial_adder_controller #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] opa, opb, sum, sum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_cout;

    // Shared full-adder cell
    assign fa_s    = opa[0] ^ opb[0] ^ carry;
    assign fa_cout = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));

    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_nxt = fa_s;
        end else begin : g_wn
            assign sum_nxt = {fa_s, sum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            sum   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                opa   <= A;
                opb   <= B;
                carry <= Cin;
                cnt   <= '0;
            end
        end else if (state == RUN) begin
            sum   <= sum_nxt;
            carry <= fa_cout;
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            cnt   <= cnt + CW'(1);
            // Result registers only move on the final bit
            if (cnt == LAST) begin
                S    <= sum_nxt;
                Cout <= fa_cout;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_controller.sv
// Scoreboard bench for serial_adder_controller: WIDTH=8 and WIDTH=1 instances.
module tb_serial_adder_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, s8;
    logic       start1, a1, b1, cin1, busy1, done1, s1, cout1;

    int n_cmp = 0;
    int n_err = 0;
    int ndone8 = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic [7:0] last_s;
    logic       last_c;

    always #5 clk = ~clk;

    serial_adder_controller #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .A(a8), .B(b8), .Cin(cin8),
        .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
    );

    serial_adder_controller #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .A(a1), .B(b1), .Cin(cin1),
        .busy(busy1), .done(done1), .S(s1), .Cout(cout1)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Monitor for the 8-bit instance
    initial forever begin
        logic [8:0] e;
        @(posedge clk);
        #1;
        if (done8) begin
            ndone8++;
            n_cmp++;
            if (q8.size() == 0) begin
                n_err++;
                $display("FAIL done8_unexpected: got S=%h Cout=%b want none",
                         s8, cout8);
            end else begin
                e = q8.pop_front();
                if ({cout8, s8} !== e) begin
                    n_err++;
                    $display("FAIL sum8: got %h want %h", {cout8, s8}, e);
                end
            end
        end
    end

    // Monitor for the 1-bit instance
    initial forever begin
        logic [1:0] e;
        @(posedge clk);
        #1;
        if (done1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL done1_unexpected: got %b%b want none",
                         cout1, s1);
            end else begin
                e = q1.pop_front();
                if ({cout1, s1} !== e) begin
                    n_err++;
                    $display("FAIL sum1: got %b%b want %b", cout1, s1, e);
                end
            end
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic c);
        int k;
        logic [8:0] e;
        e = {1'b0, a} + {1'b0, b} + {8'd0, c};
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        chk("busy_after_start", {31'd0, busy8}, 32'd1);
        k = 0;
        while (k < 20) begin
            if (done8) break;
            chk("s_hold", {23'd0, cout8, s8}, {23'd0, last_c, last_s});
            @(negedge clk);
            k++;
        end
        chk("done_latency", k, 32'd8);
        last_s = e[7:0];
        last_c = e[8];
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done8}, 32'd0);
        chk("busy_end", {31'd0, busy8}, 32'd0);
    endtask

    logic [1:0] fa_tt[8] = '{2'b00, 2'b01, 2'b01, 2'b10,
                             2'b01, 2'b10, 2'b10, 2'b11};
    logic [7:0] ta[4] = '{8'h01, 8'h80, 8'h7F, 8'hC3};
    logic [7:0] tb[4] = '{8'h02, 8'h80, 8'h01, 8'h3C};
    logic       tc[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [8:0] tx[4] = '{9'h003, 9'h101, 9'h080, 9'h100};

    initial begin
        int d0, k;
        logic [2:0] v;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        last_s = 8'h00; last_c = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_s", {23'd0, cout8, s8}, 32'd0);
        chk("rst_w1", {30'd0, busy1, done1, s1, cout1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h5A, 8'h3C, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1);

        // Restart pulses during an op are ignored
        d0 = ndone8;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h030);
        @(negedge clk); start8 = 1'b0;
        @(negedge clk); a8 = 8'hAA; b8 = 8'h55;
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (4) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        chk("restart_done_edge8", {31'd0, done8}, 32'd1);
        repeat (12) @(negedge clk);
        chk("restart_one_done", ndone8 - d0, 32'd1);
        chk("restart_idle", {31'd0, busy8}, 32'd0);
        last_s = 8'h30; last_c = 1'b0;

        // Asynchronous reset mid-op
        d0 = ndone8;
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        chk("abort_done", {31'd0, done8}, 32'd0);
        chk("abort_s", {23'd0, cout8, s8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_s = 8'h00; last_c = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_no_done", ndone8 - d0, 32'd0);
        run_op(8'h01, 8'h01, 1'b0);

        // start tied high
        @(negedge clk);
        a8 = ta[0]; b8 = tb[0]; cin8 = tc[0]; start8 = 1'b1;
        q8.push_back(tx[0]);
        for (int i = 0; i < 4; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!done8 && k < 30);
            chk("tied_period", k, (i == 0) ? 32'd9 : 32'd10);
            if (i < 3) begin
                a8 = ta[i+1]; b8 = tb[i+1]; cin8 = tc[i+1];
                q8.push_back(tx[i+1]);
            end else begin
                start8 = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
        chk("tied_idle", {31'd0, busy8}, 32'd0);

        // WIDTH=1 full-adder truth table
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
            q1.push_back(fa_tt[i]);
            @(negedge clk);
            start1 = 1'b0;
            chk("w1_busy", {31'd0, busy1}, 32'd1);
            @(negedge clk);
            chk("w1_done", {31'd0, done1}, 32'd1);
            @(negedge clk);
            chk("w1_idle", {31'd0, busy1}, 32'd0);
        end

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
